qracc_actbuf_arbiter: RTL and testbench

// - Shares the single-port activation buffer SRAM among three requesters: external bus port (LOADACTS/READACTS

---
 rtl/qracc_actbuf_arbiter_pkg.sv | 28 ++
 rtl/qracc_actbuf_arbiter_if.sv | 53 +++++
 rtl/qracc_actbuf_arbiter_wb_fifo.sv | 58 +++++
 rtl/qracc_actbuf_arbiter.sv | 111 +++++++++++
 tb/tb_qracc_actbuf_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/qracc_actbuf_arbiter_pkg.sv
// Shared types for the activation-buffer arbiter: requester identifiers
// and the round-robin helper functions.
package qracc_pkg;

  typedef enum logic [1:0] {
    ARB_EXT = 2'd0,
    ARB_IRD = 2'd1,
    ARB_WB  = 2'd2
  } arb_src_t;

  function automatic arb_src_t rr_next(input arb_src_t s);
    case (s)
      ARB_EXT: return ARB_IRD;
      ARB_IRD: return ARB_WB;
      default: return ARB_EXT;
    endcase
  endfunction

  // req bit order matches the enum encoding: [0]=EXT, [1]=IRD, [2]=WB
  function automatic arb_src_t rr_pick(input arb_src_t start, input logic [2:0] req);
    case (start)
      ARB_IRD: return req[1] ? ARB_IRD : (req[2] ? ARB_WB  : ARB_EXT);
      ARB_WB:  return req[2] ? ARB_WB  : (req[0] ? ARB_EXT : ARB_IRD);
      default: return req[0] ? ARB_EXT : (req[1] ? ARB_IRD : ARB_WB);
    endcase
  endfunction

endpackage

// File: rtl/qracc_actbuf_arbiter_if.sv
// Requester and SRAM-side signals of the activation-buffer arbiter.
// The arbiter uses the slave view; requesters/SRAM model use the master view.
interface qracc_actbuf_arbiter_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 ext_valid;
  logic                 ext_ready;
  logic                 ext_wen;
  logic [AddrWidth-1:0] ext_addr;
  logic [DataWidth-1:0] ext_wdata;
  logic                 ext_rd_valid;
  logic [DataWidth-1:0] ext_rd_data;

  logic                 ird_valid;
  logic                 ird_ready;
  logic [AddrWidth-1:0] ird_addr;
  logic                 ird_data_valid;
  logic [DataWidth-1:0] ird_data;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [AddrWidth-1:0] wb_addr;
  logic [DataWidth-1:0] wb_data;

  logic                 sram_en;
  logic                 sram_wen;
  logic [AddrWidth-1:0] sram_addr;
  logic [DataWidth-1:0] sram_wdata;
  logic [DataWidth-1:0] sram_rdata;

  modport master (
    output ext_valid, ext_wen, ext_addr, ext_wdata,
    output ird_valid, ird_addr,
    output wb_valid, wb_addr, wb_data,
    output sram_rdata,
    input  ext_ready, ext_rd_valid, ext_rd_data,
    input  ird_ready, ird_data_valid, ird_data,
    input  wb_ready,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    input  ext_valid, ext_wen, ext_addr, ext_wdata,
    input  ird_valid, ird_addr,
    input  wb_valid, wb_addr, wb_data,
    input  sram_rdata,
    output ext_ready, ext_rd_valid, ext_rd_data,
    output ird_ready, ird_data_valid, ird_data,
    output wb_ready,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/qracc_actbuf_arbiter_wb_fifo.sv
// Writeback FIFO holding {addr, data} entries until the arbiter grants WB.
// Power-of-two depth so the pointers wrap naturally.
module qracc_wb_fifo #(
  parameter int Width = 64,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [Width-1:0]         din,
  input  logic                     pop,
  output logic [Width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = PtrWidth + 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CntWidth'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qracc_actbuf_arbiter.sv
// Single-port activation buffer arbiter: ext bus, ifmap reads and buffered
// ofmap writeback share the SRAM round-robin, with WB forced when nearly full.
module qracc_actbuf_arbiter
  import qracc_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int WbDepth   = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  qracc_actbuf_arbiter_if.slave   bus,
  output logic [$clog2(WbDepth):0] wb_count
);
  localparam int CntWidth = $clog2(WbDepth) + 1;
  localparam logic [CntWidth-1:0] UrgentLevel = CntWidth'(WbDepth - 1);

  logic [AddrWidth+DataWidth-1:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic [2:0] req;
  logic       urgent;
  logic       gnt;
  logic       grant_ext;
  logic       grant_ird;
  logic       grant_wb;
  logic       tag_valid_q;
  logic       tag_valid_d;
  arb_src_t   tag_src_q;
  arb_src_t   rr_q;
  arb_src_t   rr_d;
  arb_src_t   win;

  assign req         = {!fifo_empty, bus.ird_valid, bus.ext_valid};
  assign urgent      = (wb_count >= UrgentLevel);
  assign bus.wb_ready = nrst && !fifo_full;
  assign push        = bus.wb_valid && bus.wb_ready && !clear;

  qracc_wb_fifo #(
    .Width (AddrWidth + DataWidth),
    .Depth (WbDepth)
  ) u_wb_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .push  (push),
    .din   ({bus.wb_addr, bus.wb_data}),
    .pop   (grant_wb),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (wb_count)
  );

  // Urgent WB service bypasses round-robin and leaves the pointer alone.
  always_comb begin
    win         = urgent ? ARB_WB : rr_pick(rr_q, req);
    gnt         = nrst && !clear && (urgent || (|req));
    grant_ext   = gnt && (win == ARB_EXT);
    grant_ird   = gnt && (win == ARB_IRD);
    grant_wb    = gnt && (win == ARB_WB);
    tag_valid_d = grant_ird || (grant_ext && !bus.ext_wen);
    rr_d        = rr_q;
    if (clear) begin
      rr_d = ARB_EXT;
    end else if (gnt && !urgent) begin
      rr_d = rr_next(win);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_q        <= ARB_EXT;
      tag_valid_q <= 1'b0;
      tag_src_q   <= ARB_EXT;
    end else begin
      rr_q        <= rr_d;
      tag_valid_q <= tag_valid_d;
      tag_src_q   <= win;
    end
  end

  always_comb begin
    bus.sram_en    = gnt;
    bus.sram_wen   = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (grant_ext) begin
      bus.sram_wen   = bus.ext_wen;
      bus.sram_addr  = bus.ext_addr;
      bus.sram_wdata = bus.ext_wdata;
    end else if (grant_ird) begin
      bus.sram_addr  = bus.ird_addr;
    end else if (grant_wb) begin
      bus.sram_wen   = 1'b1;
      bus.sram_addr  = fifo_dout[AddrWidth+DataWidth-1:DataWidth];
      bus.sram_wdata = fifo_dout[DataWidth-1:0];
    end
  end

  // A clear in the return cycle suppresses the pending read response.
  assign bus.ext_ready      = grant_ext;
  assign bus.ird_ready      = grant_ird;
  assign bus.ext_rd_valid   = tag_valid_q && (tag_src_q == ARB_EXT) && !clear;
  assign bus.ird_data_valid = tag_valid_q && (tag_src_q == ARB_IRD) && !clear;
  assign bus.ext_rd_data    = bus.sram_rdata;
  assign bus.ird_data       = bus.sram_rdata;

endmodule

// File: tb/tb_qracc_actbuf_arbiter.sv
// Directed vector bench for qracc_actbuf_arbiter: a per-cycle table plus a
// hand-written async-reset sequence.
module tb_qracc_actbuf_arbiter;

  typedef struct {
    logic [4:0]  ctl;    // {clear, ext_valid, ext_wen, ird_valid, wb_valid}
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] ia;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [6:0]  fl;     // {ext_ready, ird_ready, wb_ready, sram_en, sram_wen, ext_rd_valid, ird_data_valid}
    logic [31:0] xa;
    logic [31:0] xd;
    logic [2:0]  cnt;
  } vec_t;

  logic clk;
  logic nrst;
  logic clear;
  logic [2:0] wb_count;
  int checks;
  int errors;
  vec_t vecs [23];

  qracc_actbuf_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  qracc_actbuf_arbiter #(
    .AddrWidth (32),
    .DataWidth (32),
    .WbDepth   (4)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (clear),
    .bus      (bus),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge clk) begin
    if (nrst && bus.wb_valid && !bus.wb_ready) begin
      errors++;
      $display("[TB] FAIL wb_push_while_full: wb_valid=1 with wb_ready=0 at %0t", $time);
    end
  end

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [31:0] ia, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] rdat, input logic [6:0] fl, input logic [31:0] xa,
                              input logic [31:0] xd, input logic [2:0] cnt);
    vec_t v;
    v.ctl = ctl; v.ea = ea; v.ed = ed; v.ia = ia; v.wa = wa; v.wd = wd; v.rdat = rdat;
    v.fl = fl; v.xa = xa; v.xd = xd; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    clear          = 1'b0;
    bus.ext_valid  = 1'b0;
    bus.ext_wen    = 1'b0;
    bus.ext_addr   = '0;
    bus.ext_wdata  = '0;
    bus.ird_valid  = 1'b0;
    bus.ird_addr   = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus.sram_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    clear          = v.ctl[4];
    bus.ext_valid  = v.ctl[3];
    bus.ext_wen    = v.ctl[2];
    bus.ird_valid  = v.ctl[1];
    bus.wb_valid   = v.ctl[0];
    bus.ext_addr   = v.ea;
    bus.ext_wdata  = v.ed;
    bus.ird_addr   = v.ia;
    bus.wb_addr    = v.wa;
    bus.wb_data    = v.wd;
    bus.sram_rdata = v.rdat;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.ext_ready", i),      32'(bus.ext_ready),      32'(v.fl[6]));
    checkOutput($sformatf("v%0d.ird_ready", i),      32'(bus.ird_ready),      32'(v.fl[5]));
    checkOutput($sformatf("v%0d.wb_ready", i),       32'(bus.wb_ready),       32'(v.fl[4]));
    checkOutput($sformatf("v%0d.sram_en", i),        32'(bus.sram_en),        32'(v.fl[3]));
    checkOutput($sformatf("v%0d.ext_rd_valid", i),   32'(bus.ext_rd_valid),   32'(v.fl[1]));
    checkOutput($sformatf("v%0d.ird_data_valid", i), 32'(bus.ird_data_valid), 32'(v.fl[0]));
    checkOutput($sformatf("v%0d.wb_count", i),       32'(wb_count),           32'(v.cnt));
    checkOutput($sformatf("v%0d.ext_rd_data", i),    bus.ext_rd_data,         v.rdat);
    checkOutput($sformatf("v%0d.ird_data", i),       bus.ird_data,            v.rdat);
    if (v.fl[3]) begin
      checkOutput($sformatf("v%0d.sram_wen", i),  32'(bus.sram_wen), 32'(v.fl[2]));
      checkOutput($sformatf("v%0d.sram_addr", i), bus.sram_addr,     v.xa);
      if (v.fl[2]) checkOutput($sformatf("v%0d.sram_wdata", i), bus.sram_wdata, v.xd);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ext_ready"},      32'(bus.ext_ready),      32'd0);
    checkOutput({tag, ".ird_ready"},      32'(bus.ird_ready),      32'd0);
    checkOutput({tag, ".wb_ready"},       32'(bus.wb_ready),       32'd0);
    checkOutput({tag, ".sram_en"},        32'(bus.sram_en),        32'd0);
    checkOutput({tag, ".sram_wen"},       32'(bus.sram_wen),       32'd0);
    checkOutput({tag, ".ext_rd_valid"},   32'(bus.ext_rd_valid),   32'd0);
    checkOutput({tag, ".ird_data_valid"}, 32'(bus.ird_data_valid), 32'd0);
    checkOutput({tag, ".wb_count"},       32'(wb_count),           32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //              ctl       ea      ed      ia      wa      wd      rdat       fl          xa      xd      cnt
    vecs[0]  = mk(5'b00000, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h0000, 7'b0010000, 32'h00, 32'h00, 3'd0);
    vecs[1]  = mk(5'b01100, 32'h05, 32'hA5, 32'h00, 32'h00, 32'h00, 32'h0000, 7'b1011100, 32'h05, 32'hA5, 3'd0);
    vecs[2]  = mk(5'b00010, 32'h00, 32'h00, 32'h0A, 32'h00, 32'h00, 32'h0000, 7'b0111000, 32'h0A, 32'h00, 3'd0);
    vecs[3]  = mk(5'b00000, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h1234, 7'b0010001, 32'h00, 32'h00, 3'd0);
    vecs[4]  = mk(5'b00000, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h1234, 7'b0010000, 32'h00, 32'h00, 3'd0);
    vecs[5]  = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h0000, 7'b1011000, 32'h20, 32'h00, 3'd0);
    vecs[6]  = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h1111, 7'b0111010, 32'h30, 32'h00, 3'd0);
    vecs[7]  = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h2222, 7'b1011001, 32'h20, 32'h00, 3'd0);
    vecs[8]  = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h3333, 7'b0111010, 32'h30, 32'h00, 3'd0);
    vecs[9]  = mk(5'b01011, 32'h20, 32'h00, 32'h30, 32'h40, 32'hD0, 32'h4444, 7'b1011001, 32'h20, 32'h00, 3'd0);
    vecs[10] = mk(5'b01011, 32'h20, 32'h00, 32'h30, 32'h41, 32'hD1, 32'h5555, 7'b0111010, 32'h30, 32'h00, 3'd1);
    vecs[11] = mk(5'b01011, 32'h20, 32'h00, 32'h30, 32'h42, 32'hD2, 32'h6666, 7'b0011101, 32'h40, 32'hD0, 3'd2);
    vecs[12] = mk(5'b01011, 32'h20, 32'h00, 32'h30, 32'h43, 32'hD3, 32'h0000, 7'b1011000, 32'h20, 32'h00, 3'd2);
    vecs[13] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h7777, 7'b0011110, 32'h41, 32'hD1, 3'd3);
    vecs[14] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h0000, 7'b0111000, 32'h30, 32'h00, 3'd2);
    vecs[15] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h8888, 7'b0011101, 32'h42, 32'hD2, 3'd2);
    vecs[16] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h0000, 7'b1011000, 32'h20, 32'h00, 3'd1);
    vecs[17] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h9999, 7'b0111010, 32'h30, 32'h00, 3'd1);
    vecs[18] = mk(5'b01010, 32'h20, 32'h00, 32'h30, 32'h00, 32'h00, 32'h0000, 7'b0011101, 32'h43, 32'hD3, 3'd1);
    vecs[19] = mk(5'b00011, 32'h00, 32'h00, 32'h30, 32'h50, 32'hE0, 32'h0000, 7'b0111000, 32'h30, 32'h00, 3'd0);
    vecs[20] = mk(5'b11111, 32'h60, 32'h61, 32'h30, 32'h51, 32'hE1, 32'hABCD, 7'b0010000, 32'h00, 32'h00, 3'd1);
    vecs[21] = mk(5'b01110, 32'h60, 32'h61, 32'h30, 32'h00, 32'h00, 32'h0000, 7'b1011100, 32'h60, 32'h61, 3'd0);
    vecs[22] = mk(5'b00000, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h0000, 7'b0010000, 32'h00, 32'h00, 3'd0);

    driveIdle();
    nrst = 1'b0;
    @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Fresh reset so the round-robin pointer starts at EXT again.
    @(negedge clk);
    driveIdle();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

    // EXT, IRD, WB, EXT(read) with a push every cycle leaves 3 entries and a read in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.ext_valid = 1'b1;
      bus.ext_wen   = 1'b0;
      bus.ext_addr  = 32'h20;
      bus.ird_valid = 1'b1;
      bus.ird_addr  = 32'h30;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 32'h70 + 32'(k);
      bus.wb_data   = 32'hF0 + 32'(k);
    end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    checkOutput("pre_reset.wb_count", 32'(wb_count), 32'd3);
    checkOutput("pre_reset.ext_rd_valid", 32'(bus.ext_rd_valid), 32'd1);
    #1;
    nrst = 1'b0;
    #1;
    checkAllZero("async_reset");

    @(negedge clk);
    driveIdle();
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post_reset%0d.sram_en", k),  32'(bus.sram_en),  32'd0);
      checkOutput($sformatf("post_reset%0d.wb_count", k), 32'(wb_count),     32'd0);
      checkOutput($sformatf("post_reset%0d.wb_ready", k), 32'(bus.wb_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
